// File: rtl/serializer_fifo.sv
// serializer_fifo
//   Buffered readout serializer. Hit words are pushed into a DEPTH-entry
//   circular FIFO and shifted out MSB-first on DataOut, frame after frame
//   with no idle bit while words are available. EnTestPattern substitutes
//   TEST_PATTERN for the FIFO head without popping.
//
//   Build option: define SER_PARITY_EN to append one even-parity bit after
//   each frame's LSB (frame length WIDTH+1). Default: WIDTH-bit frames.
//
// Ports
//   ClkOut        in   serial bit clock, rising edge
//   Reset         in   asynchronous active-high reset
//   WriteEn       in   push DataIn this cycle
//   DataIn        in   [WIDTH-1:0] word to push
//   Enable        in   permits starting new frames
//   EnTestPattern in   frames carry TEST_PATTERN, FIFO untouched
//   Full          out  FIFO holds DEPTH words
//   Empty         out  FIFO holds 0 words
//   Count         out  [$clog2(DEPTH+1)-1:0] FIFO occupancy
//   Overflow      out  sticky, write attempted while Full
//   FrameStart    out  high during the MSB of each frame
//   DataOut       out  serial data
module serializer_fifo #(
    parameter int unsigned      WIDTH        = 27,
    parameter int unsigned      DEPTH        = 8,
    parameter logic [WIDTH-1:0] TEST_PATTERN = WIDTH'(27'b100_10101010_11001100_00001111)
) (
    input  logic                       ClkOut,
    input  logic                       Reset,
    input  logic                       WriteEn,
    input  logic [WIDTH-1:0]           DataIn,
    input  logic                       Enable,
    input  logic                       EnTestPattern,
    output logic                       Full,
    output logic                       Empty,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Overflow,
    output logic                       FrameStart,
    output logic                       DataOut
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned BW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_ovf;

    // serializer
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bitcnt;
    logic             r_dout;
    logic             r_fs;
`ifdef SER_PARITY_EN
    logic             r_par;
`endif

    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_avail;
    logic [WIDTH-1:0] w_word;
    logic [CW-1:0]    w_count_nxt;

    assign w_avail = EnTestPattern | ~r_empty;
    assign w_word  = EnTestPattern ? TEST_PATTERN : r_mem[r_rptr];
    // A full FIFO rejects the write even when a pop frees a slot this cycle.
    assign w_push  = WriteEn & ~r_full;
    assign w_pop   = w_load & ~EnTestPattern;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge ClkOut) begin
        if (w_push) r_mem[r_wptr] <= DataIn;
    end

    always_ff @(posedge ClkOut or posedge Reset) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (WriteEn && r_full) r_ovf <= 1'b1;
        end
    end

    // Load decision happens on the edge that ends the previous frame (or in IDLE).
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Enable && w_avail) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_bitcnt == '0) begin
`ifdef SER_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    if (Enable && w_avail) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                if (Enable && w_avail) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_dout holds the bit currently on the line; r_shift holds the bits
    // still to come, so the MSB is registered out on the load edge itself.
    always_ff @(posedge ClkOut or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_dout   <= 1'b0;
            r_fs     <= 1'b0;
`ifdef SER_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_fs    <= w_load;
            if (w_load) begin
                r_dout   <= w_word[WIDTH-1];
                r_shift  <= {w_word[WIDTH-2:0], 1'b0};
                r_bitcnt <= BW'(WIDTH-1);
`ifdef SER_PARITY_EN
                r_par    <= ^w_word;
`endif
            end else if (r_state == S_SHIFT && r_bitcnt != '0) begin
                r_dout   <= r_shift[WIDTH-1];
                r_shift  <= r_shift << 1;
                r_bitcnt <= r_bitcnt - 1'b1;
`ifdef SER_PARITY_EN
            end else if (r_state == S_SHIFT) begin
                r_dout   <= r_par;
`endif
            end else begin
                r_dout   <= 1'b0;
            end
        end
    end

    assign Full       = r_full;
    assign Empty      = r_empty;
    assign Count      = r_count;
    assign Overflow   = r_ovf;
    assign FrameStart = r_fs;
    assign DataOut    = r_dout;

endmodule

// File: tb/tb_serializer_fifo.sv
module tb_serializer_fifo;

    localparam int W = 27;
    localparam int D = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    localparam logic [W-1:0] TP = 27'b100_10101010_11001100_00001111;

    logic         ClkOut = 1'b0;
    logic         Reset = 1'b1;
    logic         WriteEn = 1'b0;
    logic [W-1:0] DataIn = '0;
    logic         Enable = 1'b0;
    logic         EnTestPattern = 1'b0;
    logic         Full, Empty, Overflow, FrameStart, DataOut;
    logic [3:0]   Count;

    serializer_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .ClkOut(ClkOut), .Reset(Reset), .WriteEn(WriteEn), .DataIn(DataIn),
        .Enable(Enable), .EnTestPattern(EnTestPattern), .Full(Full),
        .Empty(Empty), .Count(Count), .Overflow(Overflow),
        .FrameStart(FrameStart), .DataOut(DataOut)
    );

    always #5 ClkOut = ~ClkOut;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ClkOut);
        #1;
    endtask

    // Reference model: FIFO as a queue of words, the line as a queue of
    // remaining bits of the frame in flight.
    logic [W-1:0] mq[$];
    bit           bq[$];
    bit           m_dout, m_fs, m_ovf;

    always @(posedge ClkOut or posedge Reset) begin
        int           sz;
        logic [W-1:0] w;
        if (Reset) begin
            mq.delete();
            bq.delete();
            m_dout = 0;
            m_fs   = 0;
            m_ovf  = 0;
        end else begin
            sz   = mq.size();
            m_fs = 0;
            if (bq.size() > 0) begin
                m_dout = bq.pop_front();
            end else if (Enable && (EnTestPattern || sz > 0)) begin
                w = EnTestPattern ? TP : mq.pop_front();
                for (int i = W-1; i >= 0; i--) bq.push_back(w[i]);
`ifdef SER_PARITY_EN
                bq.push_back(^w);
`endif
                m_dout = bq.pop_front();
                m_fs   = 1;
            end else begin
                m_dout = 0;
            end
            if (WriteEn) begin
                if (sz == D) m_ovf = 1;
                else mq.push_back(DataIn);
            end
        end
    end

    always @(negedge ClkOut) begin
        if (chk_on) begin
            chk("m_count",      Count,      mq.size());
            chk("m_full",       Full,       mq.size() == D);
            chk("m_empty",      Empty,      mq.size() == 0);
            chk("m_overflow",   Overflow,   m_ovf);
            chk("m_framestart", FrameStart, m_fs);
            chk("m_dataout",    DataOut,    m_dout);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] cap;
        int fsc[$];
        int peak;
        int nfs;

        // reset state
        Reset = 1'b1;
        tick(); tick();
        chk("rst_count", Count, 0);
        chk("rst_empty", Empty, 1);
        chk("rst_full", Full, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_fs", FrameStart, 0);
        chk("rst_dout", DataOut, 0);
        Reset = 1'b0;
        chk_on = 1;

        // single word, first-bit latency and bit order
        Enable = 1; WriteEn = 1; DataIn = 27'h5A5A5A5;
        tick();
        WriteEn = 0;
        chk("t1_count", Count, 1);
        chk("t1_empty", Empty, 0);
        chk("t1_fs_early", FrameStart, 0);
        tick();
        chk("t1_fs", FrameStart, 1);
        chk("t1_count_pop", Count, 0);
        cap = '0;
        for (int i = 0; i < W; i++) begin
            cap = {cap[W-2:0], DataOut};
            tick();
        end
        chk("t1_bits", cap, 27'h5A5A5A5);
`ifdef SER_PARITY_EN
        chk("t1_parity", DataOut, 0);
        tick();
`endif
        chk("t1_idle", DataOut, 0);
        chk("t1_empty_end", Empty, 1);

        // three back-to-back words
        fsc.delete(); peak = 0;
        for (int k = 0; k < 3*FRAME + 10; k++) begin
            WriteEn = (k < 3);
            DataIn = W'($urandom);
            tick();
            if (int'(Count) > peak) peak = int'(Count);
            if (FrameStart) fsc.push_back(k);
        end
        WriteEn = 0;
        chk("t2_peak", peak, 2);
        chk("t2_nframes", fsc.size(), 3);
        if (fsc.size() == 3) begin
            chk("t2_off0", fsc[0], 1);
            chk("t2_off1", fsc[1] - fsc[0], FRAME);
            chk("t2_off2", fsc[2] - fsc[0], 2*FRAME);
        end

        // overflow: 9 writes into 8 entries with Enable low
        Enable = 0;
        for (int k = 0; k < 9; k++) begin
            WriteEn = 1; DataIn = W'($urandom);
            tick();
        end
        WriteEn = 0;
        chk("t3_full", Full, 1);
        chk("t3_count", Count, 8);
        chk("t3_ovf", Overflow, 1);
        Enable = 1;
        nfs = 0;
        for (int k = 0; k < 9*FRAME + 5; k++) begin
            tick();
            if (FrameStart) nfs++;
        end
        chk("t3_frames", nfs, 8);
        chk("t3_empty", Empty, 1);

        // test-pattern mode with two queued words
        Enable = 0;
        for (int k = 0; k < 2; k++) begin
            WriteEn = 1; DataIn = W'($urandom);
            tick();
        end
        WriteEn = 0;
        EnTestPattern = 1; Enable = 1;
        tick();
        chk("t4_fs", FrameStart, 1);
        cap = '0;
        for (int i = 0; i < W; i++) begin
            cap = {cap[W-2:0], DataOut};
            tick();
        end
        chk("t4_pattern", cap, 27'b100_10101010_11001100_00001111);
        for (int k = 0; k < 2*FRAME; k++) tick();
        chk("t4_count", Count, 2);
        EnTestPattern = 0;
        for (int k = 0; k < 4*FRAME; k++) tick();
        chk("t4_drained", Empty, 1);

        // reset mid-frame at bit 10
        WriteEn = 1; DataIn = W'($urandom);
        tick();
        DataIn = W'($urandom);
        tick();
        WriteEn = 0;
        for (int k = 0; k < 10; k++) tick();
        #2 Reset = 1;
        #1;
        chk("t5_dout", DataOut, 0);
        chk("t5_count", Count, 0);
        chk("t5_ovf", Overflow, 0);
        tick();
        Reset = 0;
        for (int k = 0; k < 40; k++) tick();
        chk("t5_quiet", DataOut, 0);

`ifdef SER_PARITY_EN
        // parity bit and 28-cycle period
        WriteEn = 1; DataIn = 27'h0000001;
        tick();
        tick();
        WriteEn = 0;
        chk("t6_fs", FrameStart, 1);
        cap = '0;
        for (int i = 0; i < W; i++) begin
            cap = {cap[W-2:0], DataOut};
            tick();
        end
        chk("t6_bits", cap, 27'h0000001);
        chk("t6_parity", DataOut, 1);
        chk("t6_fs_par", FrameStart, 0);
        tick();
        chk("t6_fs_next", FrameStart, 1);
        for (int k = 0; k < 2*FRAME; k++) tick();
`endif

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            WriteEn = ($urandom % 3) == 0;
            DataIn = W'($urandom);
            Enable = ($urandom % 8) != 0;
            EnTestPattern = ($urandom % 100) < 4;
            Reset = ($urandom % 1000) == 0;
            tick();
        end
        Reset = 0; WriteEn = 0; EnTestPattern = 0;
        tick();
        chk_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serializer_fifo.md
# serializer_fifo

Parametrised, buffered successor to the single-word readout serializer. Accepts WIDTH-bit hit words into a DEPTH-entry FIFO on ClkOut and shifts them out MSB-first on one serial line. Frames go back-to-back with no gap while data is available. A run-time test-pattern mode and an optional parity bit are provided; the block sits between the readout buffer and the output driver.

## Interface
Parameters:
- WIDTH, 27, bits per data word (≥2)
- DEPTH, 8, FIFO entries (power of two, ≥2)
- TEST_PATTERN, 27'b100_10101010_11001100_00001111 (lower WIDTH bits used), word sent in test mode

Ports:
- ClkOut  input  1  serial bit clock; all logic on rising edge
- Reset  input  1  asynchronous, active-high reset
- WriteEn  input  1  push DataIn into FIFO this cycle
- DataIn  input  WIDTH  word to push
- Enable  input  1  permits starting new frames
- EnTestPattern  input  1  frames carry TEST_PATTERN; FIFO untouched
- Full  output  1  FIFO holds DEPTH words
- Empty  output  1  FIFO holds 0 words
- Count  output  $clog2(DEPTH+1)  FIFO occupancy
- Overflow  output  1  sticky: a write was attempted while Full
- FrameStart  output  1  high during the first (MSB) bit of each frame
- DataOut  output  1  serial data

## Operation
- Reset (async): FIFO emptied, pointers 0, Count=0, Empty=1, Full=0, Overflow=0, FrameStart=0, DataOut=0, FSM→IDLE. A frame in flight is aborted immediately.
- FIFO: circular buffer, pointers wrap modulo DEPTH. A write with Full=1 is discarded and sets Overflow, even if a pop happens in the same cycle. Simultaneous push and pop when not full: Count unchanged. Overflow clears only on Reset.
- Frame source ("word available"): EnTestPattern=1 → always available, TEST_PATTERN. Otherwise available when Empty=0, taking the FIFO head; a pop happens on load.
- FSM states:
  - IDLE: DataOut=0. If Enable and a word is available → load the shift register, bit counter=WIDTH-1 → SHIFT.
  - SHIFT: DataOut=shift[WIDTH-1]. Each cycle shift left, fill 0, decrement the counter.
  - At counter=0 (last bit):
    - with parity → PARITY;
    - otherwise, if Enable and a word is available → reload (back-to-back, no idle bit) and stay in SHIFT;
    - else → IDLE.
  - PARITY (SER_PARITY_EN only): DataOut = even parity of the frame's WIDTH bits. Then the same reload-or-IDLE decision.
- EnTestPattern and Enable are sampled only at load decisions. Toggling mid-frame does not alter the frame in progress. Enable low mid-frame: the frame completes, then IDLE.
- The loaded word is a snapshot; later FIFO writes never affect it.

## Timing
- All outputs registered.
- Empty FIFO, IDLE, Enable=1: a WriteEn sampled at edge E0 makes Count/Empty update after E0. The load happens at E1, and the MSB plus FrameStart=1 appear after E1. First-bit latency: 1 cycle after the write edge.
- Frame period: WIDTH cycles, or WIDTH+1 with parity. Sustained throughput is one word per period with Enable=1 and a non-empty FIFO.
- The pop occurs on the load edge; Count decrements after that edge.
- FrameStart is high for exactly one cycle per frame.

## Configuration
- SER_PARITY_EN defined: one even-parity bit follows each frame's LSB (frame = WIDTH+1 bits); parity is also appended in test mode.
- Not defined: no PARITY state; frames are exactly WIDTH bits.

## Test plan
- Reset, Enable=1, write 27'h5A5A5A5 → FrameStart one cycle after the write edge; DataOut emits 101_1010_0101_1010_0101_1010_0101 MSB-first, then 0; Empty=1.
- Write 3 words on consecutive cycles, Enable=1 → 81 contiguous bits with no gap; FrameStart at offsets 0, 27, 54; Count peaks at 2.
- Enable=0, write 9 words (DEPTH=8) → Full=1, Count=8, Overflow=1; with Enable=1 the first 8 words are sent in order and the 9th is absent.
- EnTestPattern=1, FIFO holding 2 words → TEST_PATTERN frames repeat back-to-back; Count stays 2. Clear the mode → the queued words follow.
- Assert Reset at bit 10 of a frame → DataOut=0 and Count=0 immediately. After release with no writes, DataOut stays 0.
- SER_PARITY_EN, word 27'h0000001 → 27 data bits then parity 1; frame period 28; next FrameStart at offset 28.
